// File: rtl/adaptive_randomwalk_filter_pkg.sv
// Shared types, direction codes and helpers for the random-walk loop filter.
// Optional lock detection is enabled by defining RWF_LOCK_DETECT_EN.
package rwf_pkg;

   typedef enum logic {
      RWF_TRACK   = 1'b0,
      RWF_ACQUIRE = 1'b1
   } rwf_mode_e;

   typedef enum logic [1:0] {
      THR_HOLD = 2'd0,
      THR_ACQ  = 2'd1,
      THR_PROG = 2'd2
   } rwf_thr_sel_e;

   localparam logic [1:0] DIR_NONE = 2'd0;
   localparam logic [1:0] DIR_POS  = 2'd1;
   localparam logic [1:0] DIR_NEG  = 2'd2;

   function automatic int rwf_cnt_w(input int max_val);
      if (max_val < 1) begin
         return 1;
      end else begin
         return $clog2(max_val + 1);
      end
   endfunction

   // Zero becomes 1, anything above the largest positive count saturates.
   function automatic logic [31:0] clip_thresh(input logic [31:0] value, input int cnt_w);
      logic [31:0] max_v;
      max_v = (32'd1 << (cnt_w - 1)) - 32'd1;
      if (value == 32'd0) begin
         return 32'd1;
      end else if (value > max_v) begin
         return max_v;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/adaptive_randomwalk_filter_if.sv
// Phase-comparator / DCO-side signal bundle of the random-walk loop filter.
interface adaptive_randomwalk_filter_if #(
   parameter int CNT_W = 8
);
   logic             Enable;
   logic             Lead;
   logic             Lag;
   logic [CNT_W-1:0] ThresholdIn;
   logic             ThresholdLoad;
   logic             Positive;
   logic             Negative;
   logic             Acquire;
   logic             Locked;

   modport master (
      output Enable, Lead, Lag, ThresholdIn, ThresholdLoad,
      input  Positive, Negative, Acquire, Locked
   );

   modport slave (
      input  Enable, Lead, Lag, ThresholdIn, ThresholdLoad,
      output Positive, Negative, Acquire, Locked
   );
endinterface

// File: rtl/adaptive_randomwalk_filter_mode_ctrl.sv
// TRACK/ACQUIRE mode controller: run length, last pulse direction and lock detection
// (lock counter only built with RWF_LOCK_DETECT_EN).
module rwf_mode_ctrl
   import rwf_pkg::*;
#(
   parameter int RUN_LEN  = 4,
   parameter int LOCK_LEN = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pulse_v,
   input  logic         pulse_pos,
   output rwf_mode_e    mode,
   output rwf_thr_sel_e thr_sel,
   output logic         counter_clr,
   output logic         locked
);

   localparam int RUN_W = rwf_cnt_w(RUN_LEN);

   rwf_mode_e        mode_q, mode_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d, run_next_s;
   logic [1:0]       last_dir_q, last_dir_d, dir_s;
   logic             same_s;

   // Direction of the current pulse and the saturating run length it would produce.
   always_comb begin
      dir_s  = pulse_pos ? DIR_POS : DIR_NEG;
      same_s = (last_dir_q == dir_s);
      if (!same_s) begin
         run_next_s = RUN_W'(1'b1);
      end else if (run_cnt_q == RUN_W'(RUN_LEN)) begin
         run_next_s = run_cnt_q;
      end else begin
         run_next_s = run_cnt_q + RUN_W'(1'b1);
      end
   end

   // Mode next-state: a run of same-sign pulses enters ACQUIRE, a reversal returns to TRACK.
   always_comb begin
      mode_d      = mode_q;
      run_cnt_d   = run_cnt_q;
      last_dir_d  = last_dir_q;
      thr_sel     = THR_HOLD;
      counter_clr = 1'b0;
      if (pulse_v) begin
         last_dir_d = dir_s;
         case (mode_q)
            RWF_TRACK: begin
               if (run_next_s == RUN_W'(RUN_LEN)) begin
                  mode_d      = RWF_ACQUIRE;
                  run_cnt_d   = {RUN_W{1'b0}};
                  thr_sel     = THR_ACQ;
                  counter_clr = 1'b1;
               end else begin
                  run_cnt_d = run_next_s;
               end
            end
            RWF_ACQUIRE: begin
               if (!same_s) begin
                  mode_d      = RWF_TRACK;
                  thr_sel     = THR_PROG;
                  counter_clr = 1'b1;
               end else begin
                  mode_d = RWF_ACQUIRE;
               end
            end
            default: begin
               mode_d = RWF_TRACK;
            end
         endcase
      end else begin
         mode_d = mode_q;
      end
   end

   // Mode, run-length and last-direction registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= RWF_TRACK;
         run_cnt_q  <= {RUN_W{1'b0}};
         last_dir_q <= DIR_NONE;
      end else begin
         mode_q     <= mode_d;
         run_cnt_q  <= run_cnt_d;
         last_dir_q <= last_dir_d;
      end
   end

   assign mode = mode_q;

`ifdef RWF_LOCK_DETECT_EN
   localparam int LOCK_W = rwf_cnt_w(LOCK_LEN);

   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic              locked_q, locked_d;

   // The first pulse after reset has no predecessor and starts an alternating run.
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      if (pulse_v && (mode_q == RWF_TRACK)) begin
         if (same_s || (mode_d == RWF_ACQUIRE)) begin
            lock_cnt_d = {LOCK_W{1'b0}};
            locked_d   = 1'b0;
         end else begin
            if (lock_cnt_q == LOCK_W'(LOCK_LEN)) begin
               lock_cnt_d = lock_cnt_q;
            end else begin
               lock_cnt_d = lock_cnt_q + LOCK_W'(1'b1);
            end
            locked_d = (lock_cnt_d == LOCK_W'(LOCK_LEN));
         end
      end else begin
         lock_cnt_d = lock_cnt_q;
      end
   end

   // Lock counter and indicator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_cnt_q <= {LOCK_W{1'b0}};
         locked_q   <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign locked = locked_q;
`else
   localparam int lock_len_unused = LOCK_LEN;

   assign locked = 1'b0;
`endif

endmodule

// File: rtl/adaptive_randomwalk_filter.sv
// Random-walk ADPLL loop filter: signed integrator with programmable threshold and TRACK/ACQUIRE modes.
// Optional lock indicator is built when RWF_LOCK_DETECT_EN is defined.
module adaptive_randomwalk_filter
   import rwf_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int DEF_THRESH = 4,
   parameter int ACQ_THRESH = 2,
   parameter int RUN_LEN    = 4,
   parameter int LOCK_LEN   = 8
) (
   input logic MainClock,
   input logic Reset,
   adaptive_randomwalk_filter_if.slave bus
);

   logic signed [CNT_W-1:0] counter_q, counter_d;
   logic signed [CNT_W:0]   step_s, sum_s, act_ext_s;
   logic [CNT_W-1:0]        act_thresh_q, act_thresh_d;
   logic [CNT_W-1:0]        prog_thresh_q, prog_thresh_d;
   logic                    pending_q, pending_d;
   logic                    positive_q, positive_d;
   logic                    negative_q, negative_d;
   logic                    pos_hit_s, neg_hit_s, apply_s;
   rwf_mode_e               mode_s;
   rwf_thr_sel_e            thr_sel_s;
   logic                    counter_clr_s, locked_s;

   rwf_mode_ctrl #(
      .RUN_LEN  (RUN_LEN),
      .LOCK_LEN (LOCK_LEN)
   ) u_mode_ctrl (
      .clk         (MainClock),
      .rst         (Reset),
      .pulse_v     (pos_hit_s | neg_hit_s),
      .pulse_pos   (pos_hit_s),
      .mode        (mode_s),
      .thr_sel     (thr_sel_s),
      .counter_clr (counter_clr_s),
      .locked      (locked_s)
   );

   // Integrate one step; the sum is one bit wider so the threshold compare cannot wrap.
   always_comb begin
      case ({bus.Lead, bus.Lag})
         2'b10:   step_s = {{CNT_W{1'b0}}, 1'b1};
         2'b01:   step_s = {(CNT_W + 1){1'b1}};
         default: step_s = {(CNT_W + 1){1'b0}};
      endcase
      sum_s      = {counter_q[CNT_W-1], counter_q} + step_s;
      act_ext_s  = {1'b0, act_thresh_q};
      pos_hit_s  = bus.Enable && (sum_s == act_ext_s);
      neg_hit_s  = bus.Enable && (sum_s == -act_ext_s);
      positive_d = pos_hit_s;
      negative_d = neg_hit_s;
      if (!bus.Enable) begin
         counter_d = counter_q;
      end else if (pos_hit_s || neg_hit_s || counter_clr_s) begin
         counter_d = {CNT_W{1'b0}};
      end else begin
         counter_d = sum_s[CNT_W-1:0];
      end
   end

   // A pending threshold only takes effect in TRACK on an edge that leaves the counter at zero.
   always_comb begin
      apply_s = pending_q && (mode_s == RWF_TRACK) && (thr_sel_s == THR_HOLD)
                && (counter_d == {CNT_W{1'b0}});
      case (thr_sel_s)
         THR_ACQ:  act_thresh_d = CNT_W'(ACQ_THRESH);
         THR_PROG: act_thresh_d = prog_thresh_q;
         THR_HOLD: act_thresh_d = apply_s ? prog_thresh_q : act_thresh_q;
         default:  act_thresh_d = act_thresh_q;
      endcase
      if (bus.ThresholdLoad) begin
         prog_thresh_d = CNT_W'(clip_thresh(32'(bus.ThresholdIn), CNT_W));
         pending_d     = 1'b1;
      end else if (apply_s || (thr_sel_s == THR_PROG)) begin
         prog_thresh_d = prog_thresh_q;
         pending_d     = 1'b0;
      end else begin
         prog_thresh_d = prog_thresh_q;
         pending_d     = pending_q;
      end
   end

   // Counter, threshold and output pulse registers.
   always_ff @(posedge MainClock or posedge Reset) begin
      if (Reset) begin
         counter_q     <= {CNT_W{1'b0}};
         act_thresh_q  <= CNT_W'(DEF_THRESH);
         prog_thresh_q <= CNT_W'(DEF_THRESH);
         pending_q     <= 1'b0;
         positive_q    <= 1'b0;
         negative_q    <= 1'b0;
      end else begin
         counter_q     <= counter_d;
         act_thresh_q  <= act_thresh_d;
         prog_thresh_q <= prog_thresh_d;
         pending_q     <= pending_d;
         positive_q    <= positive_d;
         negative_q    <= negative_d;
      end
   end

   assign bus.Positive = positive_q;
   assign bus.Negative = negative_q;
   assign bus.Acquire  = (mode_s == RWF_ACQUIRE);
   assign bus.Locked   = locked_s;

endmodule

// File: tb/tb_adaptive_randomwalk_filter.sv
// Directed self-checking bench for adaptive_randomwalk_filter (default parameters).
// Lock expectations follow RWF_LOCK_DETECT_EN.
module tb_adaptive_randomwalk_filter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

`ifdef RWF_LOCK_DETECT_EN
   localparam logic LOCK_EXP = 1'b1;
`else
   localparam logic LOCK_EXP = 1'b0;
`endif

   adaptive_randomwalk_filter_if #(.CNT_W(8)) bus ();

   adaptive_randomwalk_filter dut (
      .MainClock (clk),
      .Reset     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst               = 1'b1;
      bus.Enable        = 1'b0;
      bus.Lead          = 1'b0;
      bus.Lag           = 1'b0;
      bus.ThresholdIn   = 8'd0;
      bus.ThresholdLoad = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      #2;
      total++;
      if ({bus.Positive, bus.Negative, bus.Acquire, bus.Locked} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_hold got=%b want=0000",
                  {bus.Positive, bus.Negative, bus.Acquire, bus.Locked});
      end
      rst = 1'b0;
      cyc();
      total++;
      if ({bus.Positive, bus.Negative, bus.Acquire, bus.Locked} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_release got=%b want=0000",
                  {bus.Positive, bus.Negative, bus.Acquire, bus.Locked});
      end
   endtask

   task automatic test_track_acquire();
      logic [2:0] exp_v;
      do_reset();
      bus.Enable = 1'b1;
      bus.Lead   = 1'b1;
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 4; c++) begin
            cyc();
            exp_v = {(c == 3), 1'b0, ((p == 3) && (c == 3))};
            total++;
            if ({bus.Positive, bus.Negative, bus.Acquire} !== exp_v) begin
               bad++;
               $display("FAIL track p=%0d c=%0d got=%b want=%b", p, c,
                        {bus.Positive, bus.Negative, bus.Acquire}, exp_v);
            end
         end
      end
      for (int c = 0; c < 6; c++) begin
         cyc();
         exp_v = {(c % 2 == 1), 1'b0, 1'b1};
         total++;
         if ({bus.Positive, bus.Negative, bus.Acquire} !== exp_v) begin
            bad++;
            $display("FAIL acquire_rate c=%0d got=%b want=%b", c,
                     {bus.Positive, bus.Negative, bus.Acquire}, exp_v);
         end
      end
   endtask

   task automatic test_acquire_exit();
      logic [2:0] exp_v;
      do_reset();
      bus.Enable = 1'b1;
      bus.Lead   = 1'b1;
      for (int c = 0; c < 16; c++) cyc();
      bus.Lead = 1'b0;
      bus.Lag  = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cyc();
         exp_v = (c == 1) ? 3'b010 : 3'b001;
         total++;
         if ({bus.Positive, bus.Negative, bus.Acquire} !== exp_v) begin
            bad++;
            $display("FAIL acq_exit c=%0d got=%b want=%b", c,
                     {bus.Positive, bus.Negative, bus.Acquire}, exp_v);
         end
      end
      for (int c = 0; c < 4; c++) begin
         cyc();
         exp_v = {1'b0, (c == 3), 1'b0};
         total++;
         if ({bus.Positive, bus.Negative, bus.Acquire} !== exp_v) begin
            bad++;
            $display("FAIL post_exit c=%0d got=%b want=%b", c,
                     {bus.Positive, bus.Negative, bus.Acquire}, exp_v);
         end
      end
   endtask

   task automatic test_hold_enable();
      do_reset();
      bus.Enable = 1'b1;
      bus.Lead   = 1'b1;
      for (int c = 0; c < 3; c++) cyc();
      bus.Lag = 1'b1;
      for (int c = 0; c < 20; c++) begin
         cyc();
         total++;
         if ({bus.Positive, bus.Negative} !== 2'b00) begin
            bad++;
            $display("FAIL both_hold c=%0d got=%b want=00", c, {bus.Positive, bus.Negative});
         end
      end
      bus.Lag = 1'b0;
      cyc();
      total++;
      if ({bus.Positive, bus.Negative} !== 2'b10) begin
         bad++;
         $display("FAIL hold_resume got=%b want=10", {bus.Positive, bus.Negative});
      end
      cyc();
      cyc();
      bus.Enable = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         total++;
         if ({bus.Positive, bus.Negative} !== 2'b00) begin
            bad++;
            $display("FAIL disabled c=%0d got=%b want=00", c, {bus.Positive, bus.Negative});
         end
      end
      bus.Enable = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cyc();
         total++;
         if (bus.Positive !== (c == 1)) begin
            bad++;
            $display("FAIL enable_resume c=%0d got=%b want=%b", c, bus.Positive, (c == 1));
         end
      end
   endtask

   task automatic test_threshold();
      int npulse;
      do_reset();
      bus.ThresholdIn   = 8'd0;
      bus.ThresholdLoad = 1'b1;
      cyc();
      bus.ThresholdLoad = 1'b0;
      cyc();
      bus.Enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.Lead = (i % 2 == 0);
         bus.Lag  = (i % 2 == 1);
         cyc();
         total++;
         if ({bus.Positive, bus.Negative} !== {(i % 2 == 0), (i % 2 == 1)}) begin
            bad++;
            $display("FAIL thresh_one i=%0d got=%b want=%b", i, {bus.Positive, bus.Negative},
                     {(i % 2 == 0), (i % 2 == 1)});
         end
      end
      bus.Enable        = 1'b0;
      bus.Lead          = 1'b0;
      bus.Lag           = 1'b0;
      bus.ThresholdIn   = 8'd200;
      bus.ThresholdLoad = 1'b1;
      cyc();
      bus.ThresholdLoad = 1'b0;
      cyc();
      bus.Enable = 1'b1;
      for (int d = 0; d < 2; d++) begin
         bus.Lead = (d == 0);
         bus.Lag  = (d == 1);
         npulse   = 0;
         for (int c = 0; c < 126; c++) begin
            cyc();
            if (bus.Positive || bus.Negative) npulse++;
         end
         total++;
         if (npulse != 0) begin
            bad++;
            $display("FAIL clip_early d=%0d got=%0d want=0", d, npulse);
         end
         cyc();
         total++;
         if ({bus.Positive, bus.Negative} !== {(d == 0), (d == 1)}) begin
            bad++;
            $display("FAIL clip_127 d=%0d got=%b want=%b", d, {bus.Positive, bus.Negative},
                     {(d == 0), (d == 1)});
         end
      end
      bus.Lag  = 1'b0;
      bus.Lead = 1'b1;
      cyc();
      bus.Enable        = 1'b0;
      bus.Lead          = 1'b0;
      bus.ThresholdIn   = 8'd2;
      bus.ThresholdLoad = 1'b1;
      cyc();
      bus.ThresholdLoad = 1'b0;
      bus.Enable        = 1'b1;
      bus.Lead          = 1'b1;
      cyc();
      total++;
      if (bus.Positive !== 1'b0) begin
         bad++;
         $display("FAIL pending_wait got=%b want=0", bus.Positive);
      end
      bus.Lead = 1'b0;
      bus.Lag  = 1'b1;
      cyc();
      cyc();
      bus.Lag  = 1'b0;
      bus.Lead = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cyc();
         total++;
         if (bus.Positive !== (c == 1)) begin
            bad++;
            $display("FAIL pending_apply c=%0d got=%b want=%b", c, bus.Positive, (c == 1));
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.Enable = 1'b1;
      bus.Lead   = 1'b1;
      for (int c = 0; c < 16; c++) cyc();
      total++;
      if ({bus.Positive, bus.Acquire} !== 2'b11) begin
         bad++;
         $display("FAIL pre_reset got=%b want=11", {bus.Positive, bus.Acquire});
      end
      for (int k = 0; k < 2; k++) begin
         #2;
         rst = 1'b1;
         #1;
         total++;
         if ({bus.Positive, bus.Negative, bus.Acquire, bus.Locked} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset k=%0d got=%b want=0000", k,
                     {bus.Positive, bus.Negative, bus.Acquire, bus.Locked});
         end
         #1;
         rst = 1'b0;
         if (k == 0) begin
            for (int c = 0; c < 3; c++) cyc();
         end else begin
            for (int c = 0; c < 4; c++) begin
               cyc();
               total++;
               if ({bus.Positive, bus.Acquire} !== {(c == 3), 1'b0}) begin
                  bad++;
                  $display("FAIL after_reset c=%0d got=%b want=%b", c,
                           {bus.Positive, bus.Acquire}, {(c == 3), 1'b0});
               end
            end
         end
      end
   endtask

   task automatic test_lock();
      do_reset();
      bus.Enable = 1'b1;
      for (int p = 0; p < 9; p++) begin
         bus.Lead = (p % 2 == 0) && (p != 8);
         bus.Lag  = (p % 2 == 1) || (p == 8);
         for (int c = 0; c < 4; c++) cyc();
         total++;
         if ({bus.Positive, bus.Negative, bus.Locked} !==
             {bus.Lead, bus.Lag, ((p == 7) ? LOCK_EXP : 1'b0)}) begin
            bad++;
            $display("FAIL lock p=%0d got=%b want=%b", p,
                     {bus.Positive, bus.Negative, bus.Locked},
                     {bus.Lead, bus.Lag, ((p == 7) ? LOCK_EXP : 1'b0)});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "bench did not finish");
   end

   initial begin
      test_reset();
      test_track_acquire();
      test_acquire_exit();
      test_hold_enable();
      test_threshold();
      test_async_reset();
      test_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
